// File: rtl/grant_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grant_decoder_pkg
// Brief    : Shared constants, state encoding and index helpers for the
//            grant decoder slice.
// Revision : 1.0 - initial release
// ============================================================================
package grant_decoder_pkg;

    localparam int c_idx_w     = 4;
    localparam int c_none_bit  = 3;
    localparam int c_line_w    = 3;
    localparam int c_num_lines = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    function automatic logic idx_is_none(input logic [c_idx_w-1:0] idx);
        return idx[c_none_bit];
    endfunction

    function automatic logic [c_line_w-1:0] idx_line(input logic [c_idx_w-1:0] idx);
        return idx[c_line_w-1:0];
    endfunction

endpackage : grant_decoder_pkg
`default_nettype wire

// File: rtl/grant_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : grant_decoder_if
// Brief    : Index handshake, grant/ack lines and status pulses of the
//            grant decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface grant_decoder_if;
    import grant_decoder_pkg::*;

    logic                   idx_valid;
    logic [c_idx_w-1:0]     idx;
    logic                   idx_ready;
    logic [c_num_lines-1:0] grant;
    logic [c_num_lines-1:0] ack;
    logic                   done;
    logic                   timeout;
    logic                   empty;
    logic                   busy;
    logic [c_line_w-1:0]    cur_line;

    // master: the encode stage plus requesters; slave: the decoder itself
    modport master (
        output idx_valid, idx, ack,
        input  idx_ready, grant, done, timeout, empty, busy, cur_line
    );

    modport slave (
        input  idx_valid, idx, ack,
        output idx_ready, grant, done, timeout, empty, busy, cur_line
    );

endinterface : grant_decoder_if
`default_nettype wire

// File: rtl/grant_decoder_line_decoder.sv
`default_nettype none
// ============================================================================
// Module   : grant_decoder_line_decoder
// Brief    : Combinational 3-to-8 one-hot line decoder with enable; the
//            counterpart of the request priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
module grant_decoder_line_decoder
    import grant_decoder_pkg::*;
#(
    parameter int LINES = c_num_lines
) (
    input  wire logic                i_en,
    input  wire logic [c_line_w-1:0] i_sel,
    output logic      [LINES-1:0]    o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            assign o_onehot[gi] = i_en && (i_sel == c_line_w'(gi));
        end
    endgenerate

endmodule : grant_decoder_line_decoder
`default_nettype wire

// File: rtl/grant_decoder.sv
`default_nettype none
// ============================================================================
// Module   : grant_decoder
// Brief    : Turns an encoded index into a registered one-hot grant, holds it
//            until ack or timeout, then waits for ack release.
// Revision : 1.0 - initial release
// ============================================================================
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter int LINES   = 8,
    parameter int TIMEOUT = 255,
    parameter int TCW     = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    grant_decoder_if.slave bus
);

    localparam logic [TCW-1:0] c_tmo_load = TCW'(TIMEOUT);
    localparam logic [TCW-1:0] c_tmo_last = TCW'(1);
    localparam bit             c_tmo_en   = (TIMEOUT != 0);

    state_t              state_q,    state_d;
    logic [LINES-1:0]    grant_q,    grant_d;
    logic [TCW-1:0]      cnt_q,      cnt_d;
    logic [c_line_w-1:0] cur_line_q, cur_line_d;
    logic                done_q,     done_d;
    logic                timeout_q,  timeout_d;
    logic                empty_q,    empty_d;
    logic                busy_q,     busy_d;

    logic [LINES-1:0]    w_onehot;
    logic                w_ack_cur;
    logic                w_idx_none;

    assign w_idx_none = idx_is_none(bus.idx);
    // Only the line currently owned can end a grant; stray acks never matter
    assign w_ack_cur  = bus.ack[cur_line_q];

    grant_decoder_line_decoder #(
        .LINES (LINES)
    ) u_line_decoder (
        .i_en     (!w_idx_none),
        .i_sel    (idx_line(bus.idx)),
        .o_onehot (w_onehot)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        cur_line_d = cur_line_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        empty_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.idx_valid) begin
                    if (w_idx_none) begin
                        empty_d = 1'b1;
                    end else begin
                        cur_line_d = idx_line(bus.idx);
                        grant_d    = w_onehot;
                        cnt_d      = c_tmo_load;
                        busy_d     = 1'b1;
                        state_d    = ST_GRANT;
                    end
                end
            end

            ST_GRANT: begin
                // ack is checked first so it beats a coincident timeout
                if (w_ack_cur) begin
                    grant_d = '0;
                    done_d  = 1'b1;
                    state_d = ST_RELEASE;
                end else if (c_tmo_en && (cnt_q == c_tmo_last)) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else if (c_tmo_en) begin
                    cnt_d = cnt_q - c_tmo_last;
                end
            end

            ST_RELEASE: begin
                grant_d = '0;
                if (!w_ack_cur) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            cnt_q      <= '0;
            cur_line_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            empty_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            cur_line_q <= cur_line_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            empty_q    <= empty_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.idx_ready = (state_q == ST_IDLE);
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.empty     = empty_q;
    assign bus.busy      = busy_q;
    assign bus.cur_line  = cur_line_q;

endmodule : grant_decoder
`default_nettype wire

// File: tb/tb_grant_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_grant_decoder
// Brief    : Directed bench for grant_decoder with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grant_decoder;
    import grant_decoder_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    grant_decoder_if bus();

    grant_decoder #(
        .LINES   (8),
        .TIMEOUT (TMO),
        .TCW     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 holding grant, 2 waiting for ack low.
    // m_age counts cycles the grant has been visible.
    int m_phase, m_line, m_age;
    bit m_done, m_to, m_empty;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_line = 0; m_age = 0;
            m_done = 0; m_to = 0; m_empty = 0;
        end else begin
            m_done = 0; m_to = 0; m_empty = 0;
            if (m_phase == 0) begin
                if (bus.idx_valid) begin
                    if (bus.idx >= 8) m_empty = 1;
                    else begin
                        m_line  = int'(bus.idx) % 8;
                        m_age   = 0;
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (bus.ack[m_line]) begin
                    m_done = 1; m_phase = 2;
                end else begin
                    m_age++;
                    if (TMO != 0 && m_age == TMO) begin
                        m_to = 1; m_phase = 2;
                    end
                end
            end else if (!bus.ack[m_line]) begin
                m_phase = 0;
            end
        end
    end

    logic [7:0] e_grant;
    always @(negedge clk) begin
        if (!rst) begin
            e_grant = (m_phase == 1) ? 8'(1 << m_line) : 8'h00;
            chk("model_grant",    bus.grant,     e_grant);
            chk("model_ready",    bus.idx_ready, m_phase == 0);
            chk("model_busy",     bus.busy,      m_phase != 0);
            chk("model_done",     bus.done,      m_done);
            chk("model_timeout",  bus.timeout,   m_to);
            chk("model_empty",    bus.empty,     m_empty);
            chk("model_cur_line", bus.cur_line,  m_line);
            chk("onehot0_grant",  $onehot0(bus.grant), 1);
        end
    end

    task automatic xfer(input logic [3:0] v);
        @(negedge clk);
        bus.idx_valid = 1'b1;
        bus.idx       = v;
        @(negedge clk);
        bus.idx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bus.idx_valid = 1'b0;
        bus.idx       = 4'h0;
        bus.ack       = 8'h00;
        #3;
        chk("rst_grant",    bus.grant,     8'h00);
        chk("rst_ready",    bus.idx_ready, 1);
        chk("rst_busy",     bus.busy,      0);
        chk("rst_cur_line", bus.cur_line,  0);
        chk("rst_pulses",   {bus.done, bus.timeout, bus.empty}, 0);
        @(negedge clk); #2 rst = 1'b0;

        // basic grant on line 5, ack three cycles later
        xfer(4'h5);
        chk("basic_grant", bus.grant, 8'h20);
        chk("basic_busy",  bus.busy, 1);
        chk("basic_ready", bus.idx_ready, 0);
        chk("basic_line",  bus.cur_line, 5);
        @(negedge clk); @(negedge clk);
        bus.ack = 8'h20;
        @(negedge clk);
        chk("basic_done",   bus.done, 1);
        chk("basic_drop",   bus.grant, 8'h00);
        chk("basic_no_tmo", bus.timeout, 0);
        bus.ack = 8'h00;
        @(negedge clk);
        chk("basic_ready_back", bus.idx_ready, 1);
        chk("basic_idle_busy",  bus.busy, 0);

        // none index, twice with different ignored low bits
        xfer(4'h8);
        chk("none_empty", bus.empty, 1);
        chk("none_grant", bus.grant, 8'h00);
        chk("none_busy",  bus.busy, 0);
        chk("none_line",  bus.cur_line, 5);
        @(negedge clk);
        chk("none_pulse_once", bus.empty, 0);
        xfer(4'hE);
        chk("none2_empty", bus.empty, 1);
        chk("none2_line",  bus.cur_line, 5);

        // timeout on line 2
        xfer(4'h2);
        for (int k = 0; k < TMO; k++) begin
            chk("tmo_hold", bus.grant, 8'h04);
            @(negedge clk);
        end
        chk("tmo_pulse",   bus.timeout, 1);
        chk("tmo_no_done", bus.done, 0);
        chk("tmo_drop",    bus.grant, 8'h00);
        @(negedge clk);
        chk("tmo_pulse_once", bus.timeout, 0);
        chk("tmo_ready",      bus.idx_ready, 1);

        // ack on the final counter edge beats timeout; stray ack[7] ignored
        bus.ack = 8'h80;
        xfer(4'h0);
        chk("coll_grant", bus.grant, 8'h01);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("coll_stray", bus.grant, 8'h01);
        bus.ack = 8'h81;
        @(negedge clk);
        chk("coll_done",   bus.done, 1);
        chk("coll_no_tmo", bus.timeout, 0);
        bus.ack = 8'h80;
        @(negedge clk);
        chk("coll_ready", bus.idx_ready, 1);
        bus.ack = 8'h00;

        // ack held in release; a second index must not be taken
        xfer(4'h3);
        chk("hold_grant", bus.grant, 8'h08);
        bus.ack = 8'h08;
        @(negedge clk);
        chk("hold_done", bus.done, 1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 1) begin bus.idx_valid = 1'b1; bus.idx = 4'h1; end
            if (k == 4) bus.idx_valid = 1'b0;
            chk("hold_busy",    bus.busy, 1);
            chk("hold_ready",   bus.idx_ready, 0);
            chk("hold_no_done", bus.done, 0);
            chk("hold_grant0",  bus.grant, 8'h00);
        end
        bus.ack = 8'h00;
        @(negedge clk);
        chk("hold_ready_back", bus.idx_ready, 1);
        chk("hold_line",       bus.cur_line, 3);

        // asynchronous reset mid-grant
        xfer(4'h7);
        chk("arst_grant", bus.grant, 8'h80);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant0", bus.grant, 8'h00);
        chk("arst_pulses", {bus.done, bus.timeout}, 0);
        chk("arst_busy",   bus.busy, 0);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("arst_ready", bus.idx_ready, 1);
        chk("arst_line",  bus.cur_line, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_grant_decoder
`default_nettype wire
